// File: rtl/dcache_wb_ctrl.sv
// Purpose: direct-mapped write-back / write-allocate data cache between the MEM stage and main memory.
// Latency: hits are served in the same cycle; a miss costs 1 + victim-writeback wait + fill wait + 1 cycles.
// Backpressure: stall holds the pipeline while a miss is outstanding; the memory side completes each request on a mem_rdy pulse.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   cpu_addr/re/we/wr_data    MEM-stage word access (re & we together is a store)
//   cpu_rd_data, stall        load data (valid when cpu_re & ~stall), pipeline freeze
//   mem_addr/re/we/wr_data    line request to main memory, address is {tag,index}
//   mem_rd_data, mem_rdy      fill line and one-cycle completion pulse
//   hit_cnt, miss_cnt         saturating performance counters
module dcache_wb_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_wr_data,
  output logic [15:0]      cpu_rd_data,
  output logic             stall,
  output logic [13:0]      mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [63:0]      mem_wr_data,
  input  logic [63:0]      mem_rd_data,
  input  logic             mem_rdy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int NLINES = 1 << INDEX_BITS;
  localparam int TAG_W  = 16 - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_t;

  // Line storage: valid/dirty are reset, tag/data are not (valid gates them).
  logic [63:0]      data_q  [NLINES];
  logic [TAG_W-1:0] tag_q   [NLINES];
  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;

  state_t           state_q;
  logic             mem_re_q;
  logic             mem_we_q;
  logic [13:0]      mem_addr_q;
  logic [63:0]      mem_wr_data_q;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Address split
  logic [1:0]            req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;

  assign req_off = cpu_addr[1:0];
  assign req_idx = cpu_addr[INDEX_BITS+1:2];
  assign req_tag = cpu_addr[15:INDEX_BITS+2];

  logic access;
  logic is_store;
  logic hit;
  logic idle_hit;
  logic idle_miss;

  assign access    = cpu_re | cpu_we;
  assign is_store  = cpu_we;
  assign hit       = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign idle_hit  = (state_q == S_IDLE) & access & hit;
  assign idle_miss = (state_q == S_IDLE) & access & ~hit;

  assign stall = access & ~((state_q == S_IDLE) & hit);

  // Load data comes straight from the array so a hit completes in its own cycle.
  always_comb begin
    cpu_rd_data = '0;
    if (idle_hit && cpu_re) begin
      cpu_rd_data = data_q[req_idx][{req_off, 4'b0000} +: 16];
    end
  end

  // Saturating counters: stop at all-ones rather than wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (idle_hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
    if (idle_miss && (miss_cnt_q != {CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  // Controller FSM with registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (hit) begin
              if (is_store) begin
                dirty_q[req_idx] <= 1'b1;
              end
            end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
              // Victim must reach memory before its slot is overwritten.
              state_q       <= S_WB;
              mem_we_q      <= 1'b1;
              mem_addr_q    <= {tag_q[req_idx], req_idx};
              mem_wr_data_q <= data_q[req_idx];
            end else begin
              state_q    <= S_FILL;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {req_tag, req_idx};
            end
          end
        end
        S_WB: begin
          if (mem_rdy) begin
            state_q    <= S_FILL;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= {req_tag, req_idx};
          end
        end
        S_FILL: begin
          if (mem_rdy) begin
            state_q          <= S_IDLE;
            mem_re_q         <= 1'b0;
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays: written by a store hit or by a completing fill.
  // The inputs are held stable across a miss, so req_idx/req_tag still name the line being filled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_hit && is_store) begin
        data_q[req_idx][{req_off, 4'b0000} +: 16] <= cpu_wr_data;
      end else if ((state_q == S_FILL) && mem_rdy) begin
        data_q[req_idx] <= mem_rd_data;
        tag_q[req_idx]  <= req_tag;
      end
    end
  end

  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Purpose: directed self-checking bench for dcache_wb_ctrl (hits, misses, writeback, reset abort, counter saturation).
// Latency: inputs are driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: the bench acts as main memory, raising mem_rdy at chosen points of each request.
module tb_dcache_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wr_data;
  logic [15:0] cpu_rd_data;
  logic        stall;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wr_data;
  logic [63:0] mem_rd_data;
  logic        mem_rdy;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] FILL_A = 64'hDDDD_BBBB_BBBB_DDDD;
  localparam logic [63:0] FILL_B = 64'h4444_3333_2222_1111;
  localparam logic [63:0] FILL_C = 64'h8888_7777_6666_5555;

  dcache_wb_ctrl #(.INDEX_BITS(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_re      (cpu_re),
    .cpu_we      (cpu_we),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .stall       (stall),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_rdy     (mem_rdy),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  // Protocol monitor: inputs frozen while stalled, never both memory requests at once.
  logic        prev_stall = 1'b0;
  logic        prev_rst   = 1'b1;
  logic [33:0] prev_in    = '0;

  always @(posedge clk) begin
    if (!rst && !prev_rst && prev_stall &&
        ({cpu_addr, cpu_re, cpu_we, cpu_wr_data} !== prev_in)) begin
      n_fail <= n_fail + 1;
      $display("FAIL input_stability: inputs %h changed while stalled, held value %h",
               {cpu_addr, cpu_re, cpu_we, cpu_wr_data}, prev_in);
    end
    if (mem_re && mem_we) begin
      n_fail <= n_fail + 1;
      $display("FAIL req_exclusive: mem_re=%b mem_we=%b both high", mem_re, mem_we);
    end
    prev_stall <= stall;
    prev_rst   <= rst;
    prev_in    <= {cpu_addr, cpu_re, cpu_we, cpu_wr_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wr_data = '0;
    mem_rd_data = '0; mem_rdy = 1'b0;
    #3;
    n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re: got %b want 0", mem_re); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_tests++; if (hit_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_hit_cnt: got %h want 0", hit_cnt); end
    n_tests++; if (miss_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_miss_cnt: got %h want 0", miss_cnt); end
    n_tests++; if (cpu_rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", cpu_rd_data); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_load();
    bit found;
    cpu_addr = 16'h0043; cpu_re = 1'b1;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cold_stall: got %b want 1", stall); end
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_re) begin found = 1'b1; break; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL cold_mem_re_timeout: got no mem_re want mem_re within 8 cycles"); end
    n_tests++; if (mem_addr !== 14'h0010) begin n_fail++; $display("FAIL cold_mem_addr: got %h want 0010", mem_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL cold_no_wb: got mem_we=%b want 0", mem_we); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    tick();
    tick(); mem_rdy = 1'b1; mem_rd_data = FILL_A;
    tick(); mem_rdy = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cold_hit_stall: got %b want 0", stall); end
    n_tests++; if (cpu_rd_data !== 16'hDDDD) begin n_fail++; $display("FAIL cold_rd_data: got %h want DDDD", cpu_rd_data); end
    n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL cold_mem_re_drop: got %b want 0", mem_re); end
    tick();
    n_tests++; if (hit_cnt !== 16'd1) begin n_fail++; $display("FAIL cold_hit_cnt: got %0d want 1", hit_cnt); end
    cpu_addr = 16'h0041;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hit2_stall: got %b want 0", stall); end
    n_tests++; if (cpu_rd_data !== 16'hBBBB) begin n_fail++; $display("FAIL hit2_rd_data: got %h want BBBB", cpu_rd_data); end
    tick();
    n_tests++; if (hit_cnt !== 16'd2) begin n_fail++; $display("FAIL hit2_hit_cnt: got %0d want 2", hit_cnt); end
    cpu_re = 1'b0;
  endtask

  task automatic test_dirty_writeback();
    bit found;
    cpu_addr = 16'h0042; cpu_we = 1'b1; cpu_wr_data = 16'h1234;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_hit_stall: got %b want 0", stall); end
    tick();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 16'h0842;
    n_tests++; if (hit_cnt !== 16'd3) begin n_fail++; $display("FAIL store_hit_cnt: got %0d want 3", hit_cnt); end
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_we) begin found = 1'b1; break; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL wb_timeout: got no mem_we want mem_we within 8 cycles"); end
    n_tests++; if (mem_addr !== 14'h0010) begin n_fail++; $display("FAIL wb_mem_addr: got %h want 0010", mem_addr); end
    n_tests++; if (mem_wr_data !== 64'hDDDD_1234_BBBB_DDDD) begin n_fail++; $display("FAIL wb_data: got %h want DDDD1234BBBBDDDD", mem_wr_data); end
    n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL wb_mem_re: got %b want 0", mem_re); end
    n_tests++; if (miss_cnt !== 16'd2) begin n_fail++; $display("FAIL wb_miss_cnt: got %0d want 2", miss_cnt); end
    tick(); mem_rdy = 1'b1;
    tick(); mem_rdy = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fill_mem_we_drop: got %b want 0", mem_we); end
    n_tests++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL fill_mem_re: got %b want 1", mem_re); end
    n_tests++; if (mem_addr !== 14'h0210) begin n_fail++; $display("FAIL fill_mem_addr: got %h want 0210", mem_addr); end
    tick(); mem_rdy = 1'b1; mem_rd_data = FILL_B;
    tick(); mem_rdy = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL newtag_stall: got %b want 0", stall); end
    n_tests++; if (cpu_rd_data !== 16'h3333) begin n_fail++; $display("FAIL newtag_rd_data: got %h want 3333", cpu_rd_data); end
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic test_clean_conflict();
    cpu_addr = 16'h0043; cpu_re = 1'b1;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL clean_c1_stall: got %b want 1", stall); end
    tick(); mem_rdy = 1'b1; mem_rd_data = FILL_C;
    @(negedge clk);
    n_tests++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL clean_mem_re: got %b want 1", mem_re); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL clean_no_wb: got mem_we=%b want 0", mem_we); end
    n_tests++; if (mem_addr !== 14'h0010) begin n_fail++; $display("FAIL clean_mem_addr: got %h want 0010", mem_addr); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL clean_c2_stall: got %b want 1", stall); end
    tick(); mem_rdy = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL clean_c3_stall: got %b want 0", stall); end
    n_tests++; if (cpu_rd_data !== 16'h8888) begin n_fail++; $display("FAIL clean_rd_data: got %h want 8888", cpu_rd_data); end
    n_tests++; if (miss_cnt !== 16'd3) begin n_fail++; $display("FAIL clean_miss_cnt: got %0d want 3", miss_cnt); end
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic test_reset_in_fill();
    cpu_addr = 16'h0104; cpu_re = 1'b1;
    tick();
    @(negedge clk);
    n_tests++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rstfill_mem_re_pre: got %b want 1", mem_re); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rstfill_mem_re: got %b want 0", mem_re); end
    n_tests++; if (hit_cnt !== 16'h0) begin n_fail++; $display("FAIL rstfill_hit_cnt: got %h want 0", hit_cnt); end
    n_tests++; if (miss_cnt !== 16'h0) begin n_fail++; $display("FAIL rstfill_miss_cnt: got %h want 0", miss_cnt); end
    cpu_re = 1'b0; cpu_addr = 16'h0043;
    @(negedge clk);
    rst = 1'b0;
    tick();
    cpu_re = 1'b1;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rstfill_remiss_stall: got %b want 1", stall); end
    tick(); mem_rdy = 1'b1; mem_rd_data = FILL_C;
    @(negedge clk);
    n_tests++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rstfill_refill_re: got %b want 1", mem_re); end
    n_tests++; if (mem_addr !== 14'h0010) begin n_fail++; $display("FAIL rstfill_refill_addr: got %h want 0010", mem_addr); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL rstfill_miss_cnt2: got %0d want 1", miss_cnt); end
    tick(); mem_rdy = 1'b0;
    @(negedge clk);
    n_tests++; if (cpu_rd_data !== 16'h8888) begin n_fail++; $display("FAIL rstfill_rd_data: got %h want 8888", cpu_rd_data); end
  endtask

  task automatic test_counter_saturation();
    // Access at 0x0043 keeps hitting every cycle from here on.
    repeat (65540) @(posedge clk);
    #1;
    n_tests++; if (hit_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit_cnt: got %h want FFFF", hit_cnt); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_miss_cnt: got %0d want 1", miss_cnt); end
    tick();
    n_tests++; if (hit_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want FFFF", hit_cnt); end
    cpu_re = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_dirty_writeback();
    test_clean_conflict();
    test_reset_in_fill();
    test_counter_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
